// File: rtl/fetch_stall_controller_if.sv
// Hazard-control / fetch bundle between the hazard unit, instruction memory and the fetch stall controller.
// STALL_WATCHDOG_EN adds the stall_timeout signal.
interface fetch_stall_controller_if #(
  parameter int PC_W   = 8,
  parameter int INST_W = 16,
  parameter int CNT_W  = 16
);
  logic              PCWrite;
  logic              IF_ID_Write;
  logic              CntrlSel;
  logic              BranchTaken;
  logic [PC_W-1:0]   BranchTarget;
  logic [INST_W-1:0] imem_inst1;
  logic [INST_W-1:0] imem_inst2;
  logic [PC_W-1:0]   pc;
  logic [INST_W-1:0] IF_ID_inst1;
  logic [INST_W-1:0] IF_ID_inst2;
  logic [PC_W-1:0]   IF_ID_pc;
  logic              IF_ID_valid;
  logic              ID_EX_bubble;
  logic [1:0]        state;
  logic [CNT_W-1:0]  stall_cycles;
`ifdef STALL_WATCHDOG_EN
  logic              stall_timeout;
`endif

  modport master (
    output PCWrite, IF_ID_Write, CntrlSel, BranchTaken, BranchTarget,
           imem_inst1, imem_inst2,
    input  pc, IF_ID_inst1, IF_ID_inst2, IF_ID_pc, IF_ID_valid,
           ID_EX_bubble, state, stall_cycles
`ifdef STALL_WATCHDOG_EN
    , input stall_timeout
`endif
  );

  modport slave (
    input  PCWrite, IF_ID_Write, CntrlSel, BranchTaken, BranchTarget,
           imem_inst1, imem_inst2,
    output pc, IF_ID_inst1, IF_ID_inst2, IF_ID_pc, IF_ID_valid,
           ID_EX_bubble, state, stall_cycles
`ifdef STALL_WATCHDOG_EN
    , output stall_timeout
`endif
  );
endinterface

// File: rtl/fetch_stall_controller.sv
// PC register, dual-issue IF/ID register, ID/EX bubble select and run/stall/flush tracking.
// Optional consecutive-stall watchdog enabled by defining STALL_WATCHDOG_EN.
module fetch_stall_controller #(
  parameter int              PC_W     = 8,
  parameter int              INST_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 2,
  parameter int              CNT_W    = 16
`ifdef STALL_WATCHDOG_EN
  , parameter int            MAX_STALL = 15
`endif
) (
  input  logic                      clk,
  input  logic                      reset_n,
  fetch_stall_controller_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  logic              pc_write;
  logic              redirect;
  logic [PC_W-1:0]   pc_reg, pc_next;
  logic [INST_W-1:0] inst1_reg, inst2_reg;
  logic [PC_W-1:0]   if_id_pc_reg;
  logic              valid_reg;
  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;
  logic [1:0]        state_out;
  logic              bubble_out;

  assign pc_write = bus.PCWrite;
  // A stalled cycle ignores BranchTaken: the branch operands are still hazarded.
  assign redirect = bus.PCWrite & bus.BranchTaken;

  always_comb begin
    pc_next = pc_reg;
    if (redirect)
      pc_next = bus.BranchTarget;
    else if (pc_write)
      pc_next = pc_reg + PC_W'(PC_STEP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pc_reg <= RESET_PC;
    else
      pc_reg <= pc_next;
  end

  // Redirect squashes the pair regardless of IF_ID_Write; IF_ID_pc is left as-is.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inst1_reg    <= '0;
      inst2_reg    <= '0;
      if_id_pc_reg <= '0;
      valid_reg    <= 1'b0;
    end else if (redirect) begin
      inst1_reg <= '0;
      inst2_reg <= '0;
      valid_reg <= 1'b0;
    end else if (bus.IF_ID_Write) begin
      inst1_reg    <= bus.imem_inst1;
      inst2_reg    <= bus.imem_inst2;
      if_id_pc_reg <= pc_reg;
      valid_reg    <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_reg <= ST_RUN;
    else
      state_reg <= state_next;
  end

  // Every state uses the same exit rules, so FLUSH lasts one cycle unless re-redirected.
  always_comb begin
    state_next = ST_RUN;
    if (!pc_write)
      state_next = ST_STALL;
    else if (bus.BranchTaken)
      state_next = ST_FLUSH;
  end

  always_comb begin
    state_out  = state_reg;
    bubble_out = bus.CntrlSel | ~valid_reg;
  end

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (!pc_write && (stall_cnt_reg != {CNT_W{1'b1}}))
      stall_cnt_next = stall_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_cnt_reg <= '0;
    else
      stall_cnt_reg <= stall_cnt_next;
  end

  assign bus.pc           = pc_reg;
  assign bus.IF_ID_inst1  = inst1_reg;
  assign bus.IF_ID_inst2  = inst2_reg;
  assign bus.IF_ID_pc     = if_id_pc_reg;
  assign bus.IF_ID_valid  = valid_reg;
  assign bus.ID_EX_bubble = bubble_out;
  assign bus.state        = state_out;
  assign bus.stall_cycles = stall_cnt_reg;

`ifdef STALL_WATCHDOG_EN
  localparam logic [4:0] MAX_STALL_W = 5'(MAX_STALL);

  logic [4:0] wd_cnt_reg, wd_cnt_next;
  logic       timeout_reg, timeout_next;

  // Run length of the current stall; saturates so a long stall cannot wrap back to zero.
  always_comb begin
    wd_cnt_next  = wd_cnt_reg;
    timeout_next = timeout_reg;
    if (pc_write)
      wd_cnt_next = '0;
    else if (wd_cnt_reg != 5'h1f)
      wd_cnt_next = wd_cnt_reg + 1'b1;
    if (!pc_write && (wd_cnt_next >= MAX_STALL_W))
      timeout_next = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      wd_cnt_reg  <= wd_cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  assign bus.stall_timeout = timeout_reg;
`endif

endmodule

// File: tb/tb_fetch_stall_controller.sv
// Self-checking bench for fetch_stall_controller: directed scenarios plus randomized traffic
// against a behavioural model of the fetch/stall rules.
module tb_fetch_stall_controller;
  localparam int CNT_W     = 6;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  fetch_stall_controller_if #(.PC_W(8), .INST_W(16), .CNT_W(CNT_W)) bus ();

  fetch_stall_controller #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  m_pc;
  logic [7:0]  m_ipc;
  logic [15:0] m_i1;
  logic [15:0] m_i2;
  logic        m_valid;
  logic [1:0]  m_state;
  int          m_stall;
  int          m_wd;
  logic        m_to;

  task automatic model_reset();
    m_pc = 8'h00; m_ipc = 8'h00; m_i1 = '0; m_i2 = '0; m_valid = 1'b0;
    m_state = 2'd0; m_stall = 0; m_wd = 0; m_to = 1'b0;
  endtask

  task automatic apply_reset();
    bus.PCWrite = 1'b1; bus.IF_ID_Write = 1'b1; bus.CntrlSel = 1'b0;
    bus.BranchTaken = 1'b0; bus.BranchTarget = '0;
    bus.imem_inst1 = '0; bus.imem_inst2 = '0;
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  // One clock edge: drive inputs, advance the model by the fetch/stall rules, sample 1 ns after the edge.
  task automatic cycle(input logic pcw, input logic ifw, input logic cs, input logic bt,
                       input logic [7:0] tgt, input logic [15:0] i1, input logic [15:0] i2);
    bus.PCWrite = pcw; bus.IF_ID_Write = ifw; bus.CntrlSel = cs;
    bus.BranchTaken = bt; bus.BranchTarget = tgt;
    bus.imem_inst1 = i1; bus.imem_inst2 = i2;
    @(posedge clk);
    if (pcw && bt) begin
      m_i1 = '0; m_i2 = '0; m_valid = 1'b0;
    end else if (ifw) begin
      m_i1 = i1; m_i2 = i2; m_ipc = m_pc; m_valid = 1'b1;
    end
    if (pcw) m_pc = bt ? tgt : 8'((int'(m_pc) + 2) % 256);
    m_state = !pcw ? 2'd1 : (bt ? 2'd2 : 2'd0);
    if (!pcw) m_stall = (m_stall < STALL_MAX) ? m_stall + 1 : STALL_MAX;
    if (pcw) m_wd = 0;
    else begin
      m_wd = (m_wd < 31) ? m_wd + 1 : 31;
      if (m_wd >= 15) m_to = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    bus.CntrlSel = 1'b0;
    apply_reset();
    total++; if (bus.pc !== 8'h00) begin bad++; $display("FAIL reset_pc got=%0h exp=0", bus.pc); end
    total++; if (bus.IF_ID_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", bus.IF_ID_valid); end
    total++; if (bus.IF_ID_inst1 !== 16'h0 || bus.IF_ID_inst2 !== 16'h0) begin bad++; $display("FAIL reset_inst got=%0h/%0h exp=0/0", bus.IF_ID_inst1, bus.IF_ID_inst2); end
    total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
    total++; if (bus.stall_cycles !== '0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", bus.stall_cycles); end
    total++; if (bus.ID_EX_bubble !== 1'b1) begin bad++; $display("FAIL reset_bubble got=%0b exp=1", bus.ID_EX_bubble); end
    $display("reset: pc=%0h valid=%0b state=%0d", bus.pc, bus.IF_ID_valid, bus.state);
  endtask

  task automatic test_normal();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'hA0A0, 16'hB0B0);
    total++; if (bus.pc !== 8'h02) begin bad++; $display("FAIL normal1_pc got=%0h exp=2", bus.pc); end
    total++; if (bus.IF_ID_inst1 !== 16'hA0A0 || bus.IF_ID_inst2 !== 16'hB0B0) begin bad++; $display("FAIL normal1_inst got=%0h/%0h exp=a0a0/b0b0", bus.IF_ID_inst1, bus.IF_ID_inst2); end
    total++; if (bus.IF_ID_valid !== 1'b1 || bus.IF_ID_pc !== 8'h00) begin bad++; $display("FAIL normal1_valid_pc got=%0b/%0h exp=1/0", bus.IF_ID_valid, bus.IF_ID_pc); end
    $display("normal: pc=%0h if_id=%0h/%0h", bus.pc, bus.IF_ID_inst1, bus.IF_ID_inst2);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'hC0C0, 16'hD0D0);
    total++; if (bus.pc !== 8'h04) begin bad++; $display("FAIL normal2_pc got=%0h exp=4", bus.pc); end
    total++; if (bus.IF_ID_inst1 !== 16'hC0C0 || bus.IF_ID_inst2 !== 16'hD0D0) begin bad++; $display("FAIL normal2_inst got=%0h/%0h exp=c0c0/d0d0", bus.IF_ID_inst1, bus.IF_ID_inst2); end
    total++; if (bus.IF_ID_pc !== 8'h02 || bus.state !== 2'd0) begin bad++; $display("FAIL normal2_pc_state got=%0h/%0d exp=2/0", bus.IF_ID_pc, bus.state); end
    $display("normal: pc=%0h if_id=%0h/%0h", bus.pc, bus.IF_ID_inst1, bus.IF_ID_inst2);
  endtask

  task automatic test_stall();
    for (int k = 0; k < 2; k++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'hE0E0, 16'hF0F0);
    total++; if (bus.pc !== 8'h04) begin bad++; $display("FAIL stall_pc got=%0h exp=4", bus.pc); end
    total++; if (bus.IF_ID_inst1 !== 16'hC0C0 || bus.IF_ID_valid !== 1'b1) begin bad++; $display("FAIL stall_hold got=%0h/%0b exp=c0c0/1", bus.IF_ID_inst1, bus.IF_ID_valid); end
    total++; if (bus.state !== 2'd1) begin bad++; $display("FAIL stall_state got=%0d exp=1", bus.state); end
    total++; if (bus.stall_cycles !== 6'd2) begin bad++; $display("FAIL stall_count got=%0d exp=2", bus.stall_cycles); end
    total++; if (bus.ID_EX_bubble !== 1'b1) begin bad++; $display("FAIL stall_bubble_on got=%0b exp=1", bus.ID_EX_bubble); end
    bus.CntrlSel = 1'b0;
    #1;
    total++; if (bus.ID_EX_bubble !== 1'b0) begin bad++; $display("FAIL stall_bubble_off got=%0b exp=0", bus.ID_EX_bubble); end
    $display("stall: pc=%0h state=%0d stall_cycles=%0d", bus.pc, bus.state, bus.stall_cycles);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'hE0E0, 16'hF0F0);
    total++; if (bus.pc !== 8'h06 || bus.IF_ID_inst1 !== 16'hE0E0 || bus.state !== 2'd0) begin bad++; $display("FAIL stall_release got=%0h/%0h/%0d exp=6/e0e0/0", bus.pc, bus.IF_ID_inst1, bus.state); end
    $display("release: pc=%0h if_id=%0h state=%0d", bus.pc, bus.IF_ID_inst1, bus.state);
  endtask

  task automatic test_redirect();
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h40, 16'h1111, 16'h2222);
    total++; if (bus.pc !== 8'h40) begin bad++; $display("FAIL redir_pc got=%0h exp=40", bus.pc); end
    total++; if (bus.IF_ID_valid !== 1'b0 || bus.IF_ID_inst1 !== 16'h0 || bus.IF_ID_inst2 !== 16'h0) begin bad++; $display("FAIL redir_squash got=%0b/%0h/%0h exp=0/0/0", bus.IF_ID_valid, bus.IF_ID_inst1, bus.IF_ID_inst2); end
    total++; if (bus.ID_EX_bubble !== 1'b1 || bus.state !== 2'd2) begin bad++; $display("FAIL redir_bubble_state got=%0b/%0d exp=1/2", bus.ID_EX_bubble, bus.state); end
    $display("redirect: pc=%0h valid=%0b state=%0d", bus.pc, bus.IF_ID_valid, bus.state);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'h3333, 16'h4444);
    total++; if (bus.IF_ID_valid !== 1'b1 || bus.IF_ID_inst1 !== 16'h3333 || bus.IF_ID_pc !== 8'h40) begin bad++; $display("FAIL redir_target_pair got=%0b/%0h/%0h exp=1/3333/40", bus.IF_ID_valid, bus.IF_ID_inst1, bus.IF_ID_pc); end
    total++; if (bus.pc !== 8'h42 || bus.state !== 2'd0) begin bad++; $display("FAIL redir_after got=%0h/%0d exp=42/0", bus.pc, bus.state); end
    $display("after redirect: pc=%0h if_id_pc=%0h state=%0d", bus.pc, bus.IF_ID_pc, bus.state);
  endtask

  task automatic test_branch_during_stall();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h80, 16'h5555, 16'h6666);
    total++; if (bus.pc !== 8'h42 || bus.state !== 2'd1 || bus.IF_ID_valid !== 1'b1) begin bad++; $display("FAIL bstall_hold got=%0h/%0d/%0b exp=42/1/1", bus.pc, bus.state, bus.IF_ID_valid); end
    $display("branch in stall: pc=%0h state=%0d", bus.pc, bus.state);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 16'h5555, 16'h6666);
    total++; if (bus.pc !== 8'h80 || bus.state !== 2'd2 || bus.IF_ID_valid !== 1'b0) begin bad++; $display("FAIL bstall_release got=%0h/%0d/%0b exp=80/2/0", bus.pc, bus.state, bus.IF_ID_valid); end
    $display("released branch: pc=%0h state=%0d", bus.pc, bus.state);
  endtask

  task automatic test_wrap();
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'hFE, 16'h0, 16'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'h7777, 16'h8888);
    total++; if (bus.pc !== 8'h00) begin bad++; $display("FAIL wrap_pc got=%0h exp=0", bus.pc); end
    total++; if (bus.IF_ID_pc !== 8'hFE || bus.IF_ID_valid !== 1'b1) begin bad++; $display("FAIL wrap_ifid got=%0h/%0b exp=fe/1", bus.IF_ID_pc, bus.IF_ID_valid); end
    $display("wrap: pc=%0h if_id_pc=%0h", bus.pc, bus.IF_ID_pc);
  endtask

  task automatic test_async_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0, 16'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0, 16'h0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    total++; if (bus.pc !== 8'h00 || bus.IF_ID_pc !== 8'h00) begin bad++; $display("FAIL areset_pc got=%0h/%0h exp=0/0", bus.pc, bus.IF_ID_pc); end
    total++; if (bus.IF_ID_valid !== 1'b0 || bus.IF_ID_inst1 !== 16'h0 || bus.IF_ID_inst2 !== 16'h0) begin bad++; $display("FAIL areset_ifid got=%0b/%0h/%0h exp=0/0/0", bus.IF_ID_valid, bus.IF_ID_inst1, bus.IF_ID_inst2); end
    total++; if (bus.state !== 2'd0 || bus.stall_cycles !== '0) begin bad++; $display("FAIL areset_state got=%0d/%0d exp=0/0", bus.state, bus.stall_cycles); end
    $display("async reset mid-stall: pc=%0h state=%0d stall_cycles=%0d", bus.pc, bus.state, bus.stall_cycles);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_saturate();
    for (int k = 0; k < STALL_MAX; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0, 16'h0);
    total++; if (bus.stall_cycles !== 6'd63) begin bad++; $display("FAIL sat_reach got=%0d exp=63", bus.stall_cycles); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0, 16'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0, 16'h0);
    total++; if (bus.stall_cycles !== 6'd63) begin bad++; $display("FAIL sat_hold got=%0d exp=63", bus.stall_cycles); end
    $display("saturate: stall_cycles=%0d", bus.stall_cycles);
  endtask

`ifdef STALL_WATCHDOG_EN
  task automatic test_watchdog();
    apply_reset();
    for (int k = 0; k < 14; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0, 16'h0);
    total++; if (bus.stall_timeout !== 1'b0) begin bad++; $display("FAIL wd_14 got=%0b exp=0", bus.stall_timeout); end
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0, 16'h0);
    for (int k = 0; k < 14; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0, 16'h0);
    total++; if (bus.stall_timeout !== 1'b0) begin bad++; $display("FAIL wd_14b got=%0b exp=0", bus.stall_timeout); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0, 16'h0);
    total++; if (bus.stall_timeout !== 1'b1) begin bad++; $display("FAIL wd_15 got=%0b exp=1", bus.stall_timeout); end
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0, 16'h0);
    total++; if (bus.stall_timeout !== 1'b1) begin bad++; $display("FAIL wd_sticky got=%0b exp=1", bus.stall_timeout); end
    $display("watchdog: stall_timeout=%0b", bus.stall_timeout);
    apply_reset();
  endtask
`endif

  task automatic test_random();
    logic pcw, ifw, cs, bt;
    logic [7:0] tgt;
    for (int n = 0; n < 300; n++) begin
      pcw = ($urandom_range(0, 3) != 0);
      ifw = ($urandom_range(0, 4) != 0);
      cs  = ($urandom_range(0, 5) == 0);
      bt  = ($urandom_range(0, 6) == 0);
      tgt = 8'($urandom);
      cycle(pcw, ifw, cs, bt, tgt, 16'($urandom), 16'($urandom));
      total++; if (bus.pc !== m_pc) begin bad++; $display("FAIL rand_pc n=%0d got=%0h exp=%0h", n, bus.pc, m_pc); end
      total++; if (bus.IF_ID_valid !== m_valid) begin bad++; $display("FAIL rand_valid n=%0d got=%0b exp=%0b", n, bus.IF_ID_valid, m_valid); end
      total++; if (bus.IF_ID_inst1 !== m_i1 || bus.IF_ID_inst2 !== m_i2) begin bad++; $display("FAIL rand_inst n=%0d got=%0h/%0h exp=%0h/%0h", n, bus.IF_ID_inst1, bus.IF_ID_inst2, m_i1, m_i2); end
      if (m_valid) begin
        total++; if (bus.IF_ID_pc !== m_ipc) begin bad++; $display("FAIL rand_ifid_pc n=%0d got=%0h exp=%0h", n, bus.IF_ID_pc, m_ipc); end
      end
      total++; if (bus.state !== m_state) begin bad++; $display("FAIL rand_state n=%0d got=%0d exp=%0d", n, bus.state, m_state); end
      total++; if (int'(bus.stall_cycles) != m_stall) begin bad++; $display("FAIL rand_stall n=%0d got=%0d exp=%0d", n, bus.stall_cycles, m_stall); end
      total++; if (bus.ID_EX_bubble !== (cs | ~m_valid)) begin bad++; $display("FAIL rand_bubble n=%0d got=%0b exp=%0b", n, bus.ID_EX_bubble, cs | ~m_valid); end
`ifdef STALL_WATCHDOG_EN
      total++; if (bus.stall_timeout !== m_to) begin bad++; $display("FAIL rand_timeout n=%0d got=%0b exp=%0b", n, bus.stall_timeout, m_to); end
`endif
      $display("rand %0d: pcw=%0b ifw=%0b bt=%0b pc=%0h valid=%0b state=%0d", n, pcw, ifw, bt, bus.pc, bus.IF_ID_valid, bus.state);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    model_reset();
    test_reset();
    test_normal();
    test_stall();
    test_redirect();
    test_branch_during_stall();
    test_wrap();
    test_async_reset();
    test_saturate();
`ifdef STALL_WATCHDOG_EN
    test_watchdog();
`endif
    apply_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
